// File: rtl/a51_pkg.sv
// Shared constants and types for the A5/1 keystream cipher: register geometry,
// feedback taps, clocking/output bit positions and control encodings.
package a51_pkg;

  localparam int unsigned R1_LEN = 19;
  localparam int unsigned R2_LEN = 22;
  localparam int unsigned R3_LEN = 23;

  // Feedback taps as bit masks: R1 {13,16,17,18}, R2 {20,21}, R3 {7,20,21,22}
  localparam logic [R1_LEN-1:0] R1_TAPS = 19'h7_2000;
  localparam logic [R2_LEN-1:0] R2_TAPS = 22'h30_0000;
  localparam logic [R3_LEN-1:0] R3_TAPS = 23'h70_0080;

  localparam int unsigned R1_CLK = 8;
  localparam int unsigned R2_CLK = 10;
  localparam int unsigned R3_CLK = 10;

  localparam int unsigned R1_OUT = 18;
  localparam int unsigned R2_OUT = 21;
  localparam int unsigned R3_OUT = 22;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD_KEY,
    ST_LOAD_FRAME,
    ST_WARMUP,
    ST_RUN
  } state_e;

  typedef enum logic [1:0] {
    LFSR_HOLD,
    LFSR_LOAD,
    LFSR_MAJ
  } lfsr_mode_e;

endpackage

// File: rtl/a51_stream_cipher_if.sv
// Key/frame provisioning and valid/ready data stream bundle of the A5/1 cipher.
interface a51_stream_cipher_if #(
  parameter int unsigned KEY_W   = 64,
  parameter int unsigned FRAME_W = 22,
  parameter int unsigned DATA_W  = 8
);
  logic [KEY_W-1:0]   key;
  logic [FRAME_W-1:0] frame;
  logic               start;
  logic               busy;
  logic [DATA_W-1:0]  in_data;
  logic               in_valid;
  logic               in_ready;
  logic [DATA_W-1:0]  out_data;
  logic               out_valid;
  logic               out_ready;

  modport master (
    output key, frame, start, in_data, in_valid, out_ready,
    input  busy, in_ready, out_data, out_valid
  );

  modport slave (
    input  key, frame, start, in_data, in_valid, out_ready,
    output busy, in_ready, out_data, out_valid
  );
endinterface

// File: rtl/a51_lfsr_core.sv
// The three A5/1 LFSRs with unconditional load-stepping and majority stepping.
// z_o is the keystream bit of the register values after the requested step.
module a51_lfsr_core
  import a51_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clear_i,
  input  lfsr_mode_e mode_i,
  input  logic       load_bit_i,
  output logic       z_o
);

  logic [R1_LEN-1:0] r1_q, r1_d;
  logic [R2_LEN-1:0] r2_q, r2_d;
  logic [R3_LEN-1:0] r3_q, r3_d;
  logic              maj, step1, step2, step3, inj;

  always_comb begin
    maj   = (r1_q[R1_CLK] & r2_q[R2_CLK]) | (r1_q[R1_CLK] & r3_q[R3_CLK]) |
            (r2_q[R2_CLK] & r3_q[R3_CLK]);
    step1 = 1'b0;
    step2 = 1'b0;
    step3 = 1'b0;
    inj   = 1'b0;
    case (mode_i)
      LFSR_LOAD: begin
        step1 = 1'b1;
        step2 = 1'b1;
        step3 = 1'b1;
        inj   = load_bit_i;
      end
      LFSR_MAJ: begin
        step1 = (r1_q[R1_CLK] == maj);
        step2 = (r2_q[R2_CLK] == maj);
        step3 = (r3_q[R3_CLK] == maj);
      end
      default: ;
    endcase

    r1_d = step1 ? {r1_q[R1_LEN-2:0], (^(r1_q & R1_TAPS)) ^ inj} : r1_q;
    r2_d = step2 ? {r2_q[R2_LEN-2:0], (^(r2_q & R2_TAPS)) ^ inj} : r2_q;
    r3_d = step3 ? {r3_q[R3_LEN-2:0], (^(r3_q & R3_TAPS)) ^ inj} : r3_q;
    if (clear_i) begin
      r1_d = '0;
      r2_d = '0;
      r3_d = '0;
    end
    z_o = r1_d[R1_OUT] ^ r2_d[R2_OUT] ^ r3_d[R3_OUT];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r1_q <= '0;
      r2_q <= '0;
      r3_q <= '0;
    end else begin
      r1_q <= r1_d;
      r2_q <= r2_d;
      r3_q <= r3_d;
    end
  end

endmodule

// File: rtl/a51_stream_cipher.sv
// A5/1 stream cipher: key/frame setup, warm-up, then DATA_W-bit keystream words
// XORed onto a valid/ready data stream.
module a51_stream_cipher
  import a51_pkg::*;
#(
  parameter int unsigned KEY_W   = 64,
  parameter int unsigned FRAME_W = 22,
  parameter int unsigned WARMUP  = 100,
  parameter int unsigned DATA_W  = 8
) (
  input logic               clk,
  input logic               rst,
  a51_stream_cipher_if.slave bus
);

  localparam int unsigned CNT_MAX = (KEY_W > FRAME_W) ?
                                    ((KEY_W > WARMUP) ? KEY_W : WARMUP) :
                                    ((FRAME_W > WARMUP) ? FRAME_W : WARMUP);
  localparam int unsigned CNT_W = $clog2(CNT_MAX + 1);
  localparam int unsigned KS_W  = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] KEY_LAST   = CNT_W'(KEY_W - 1);
  localparam logic [CNT_W-1:0] FRAME_LAST = CNT_W'(FRAME_W - 1);
  localparam logic [CNT_W-1:0] WARM_LAST  = CNT_W'((WARMUP > 0) ? WARMUP - 1 : 0);
  localparam logic [KS_W-1:0]  KS_FULL    = KS_W'(DATA_W);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [KEY_W-1:0]   key_q, key_d;
  logic [FRAME_W-1:0] frame_q, frame_d;
  logic [DATA_W-1:0]  ks_buf_q, ks_buf_d;
  logic [KS_W-1:0]    ks_cnt_q, ks_cnt_d;
  logic [DATA_W-1:0]  out_data_q, out_data_d;
  logic               out_valid_q, out_valid_d;

  lfsr_mode_e mode;
  logic       load_bit, clear, z, ks_full, in_ready, accept;

  a51_lfsr_core u_core (
    .clk       (clk),
    .rst       (rst),
    .clear_i   (clear),
    .mode_i    (mode),
    .load_bit_i(load_bit),
    .z_o       (z)
  );

  assign ks_full  = (ks_cnt_q == KS_FULL);
  assign in_ready = (state_q == ST_RUN) && ks_full && (!out_valid_q || bus.out_ready) &&
                    !bus.start;
  assign accept   = in_ready && bus.in_valid;

  assign bus.busy      = (state_q == ST_LOAD_KEY) || (state_q == ST_LOAD_FRAME) ||
                         (state_q == ST_WARMUP);
  assign bus.in_ready  = in_ready;
  assign bus.out_data  = out_data_q;
  assign bus.out_valid = out_valid_q;

  // Key and frame are held as right-shifting copies so the next load bit is always bit 0.
  always_comb begin
    clear    = bus.start;
    mode     = LFSR_HOLD;
    load_bit = 1'b0;
    if (!bus.start) begin
      case (state_q)
        ST_LOAD_KEY: begin
          mode     = LFSR_LOAD;
          load_bit = key_q[0];
        end
        ST_LOAD_FRAME: begin
          mode     = LFSR_LOAD;
          load_bit = frame_q[0];
        end
        ST_WARMUP: mode = LFSR_MAJ;
        ST_RUN:    mode = ks_full ? LFSR_HOLD : LFSR_MAJ;
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    key_d       = key_q;
    frame_d     = frame_q;
    ks_buf_d    = ks_buf_q;
    ks_cnt_d    = ks_cnt_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    if (bus.start) begin
      state_d     = ST_LOAD_KEY;
      cnt_d       = '0;
      key_d       = bus.key;
      frame_d     = bus.frame;
      ks_buf_d    = '0;
      ks_cnt_d    = '0;
      out_data_d  = '0;
      out_valid_d = 1'b0;
    end else begin
      case (state_q)
        ST_LOAD_KEY: begin
          key_d = key_q >> 1;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == KEY_LAST) begin
            cnt_d   = '0;
            state_d = ST_LOAD_FRAME;
          end
        end
        ST_LOAD_FRAME: begin
          frame_d = frame_q >> 1;
          cnt_d   = cnt_q + 1'b1;
          if (cnt_q == FRAME_LAST) begin
            cnt_d   = '0;
            state_d = (WARMUP == 0) ? ST_RUN : ST_WARMUP;
          end
        end
        ST_WARMUP: begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == WARM_LAST) begin
            cnt_d   = '0;
            state_d = ST_RUN;
          end
        end
        ST_RUN: begin
          // Shifting in at the MSB leaves the first bit of the word at the LSB once full.
          if (!ks_full) begin
            ks_buf_d = {z, ks_buf_q[DATA_W-1:1]};
            ks_cnt_d = ks_cnt_q + 1'b1;
          end
        end
        default: ;
      endcase
      if (accept) begin
        out_data_d  = bus.in_data ^ ks_buf_q;
        out_valid_d = 1'b1;
        ks_cnt_d    = '0;
      end else if (bus.out_ready) begin
        out_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      key_q       <= '0;
      frame_q     <= '0;
      ks_buf_q    <= '0;
      ks_cnt_q    <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      key_q       <= key_d;
      frame_q     <= frame_d;
      ks_buf_q    <= ks_buf_d;
      ks_cnt_q    <= ks_cnt_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule
